// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: accumulates coin credit, checks it against a
// per-item price table, handshakes with the dispenser and pays out change or a
// refund one CHANGE_UNIT per cycle. All outputs are registered.
module vend_txn_controller #(
  parameter int unsigned PRICE0      = 50,
  parameter int unsigned PRICE1      = 75,
  parameter int unsigned PRICE2      = 100,
  parameter int unsigned PRICE3      = 125,
  parameter int unsigned CHANGE_UNIT = 5,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin,
  input  logic [1:0] coin_val,
  input  logic       select,
  input  logic [1:0] item_sel,
  input  logic       cancel,
  input  logic       dispense_ack,
  output logic [2:0] state,
  output logic [7:0] credit,
  output logic [1:0] item_out,
  output logic       dispense_req,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       insufficient
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAccept   = 3'd1,
    StCheck    = 3'd2,
    StDispense = 3'd3,
    StChange   = 3'd4,
    StRefund   = 3'd5
  } state_e;

  localparam int unsigned Tw   = $clog2(TIMEOUT);
  localparam logic [7:0]  Unit = 8'(CHANGE_UNIT);

  state_e        state_q;
  logic [Tw-1:0] tcnt_q;
  logic [7:0]    coin_cents;
  logic [8:0]    coin_sum;
  logic          coin_ok;
  logic [7:0]    price;

  assign state = state_q;

  // Decode the coin denomination into cents.
  always_comb begin
    case (coin_val)
      2'd0:    coin_cents = 8'd5;
      2'd1:    coin_cents = 8'd10;
      2'd2:    coin_cents = 8'd25;
      default: coin_cents = 8'd100;
    endcase
  end

  // Price lookup for the latched item.
  always_comb begin
    case (item_out)
      2'd0:    price = 8'(PRICE0);
      2'd1:    price = 8'(PRICE1);
      2'd2:    price = 8'(PRICE2);
      default: price = 8'(PRICE3);
    endcase
  end

  // 9-bit sum so an overflowing coin is refused rather than wrapping.
  assign coin_sum = {1'b0, credit} + {1'b0, coin_cents};
  assign coin_ok  = coin && !cancel && !coin_sum[8] &&
                    ((state_q == StIdle) || (state_q == StAccept));

  // Transaction FSM with registered outputs and single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      credit       <= 8'd0;
      item_out     <= 2'd0;
      dispense_req <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      tcnt_q       <= '0;
    end else begin
      change_pulse <= 1'b0;
      insufficient <= 1'b0;
      coin_reject  <= coin && !coin_ok;
      case (state_q)
        StIdle: begin
          if (coin_ok) begin
            credit  <= coin_sum[7:0];
            tcnt_q  <= '0;
            state_q <= StAccept;
          end
        end
        StAccept: begin
          if (cancel) begin
            state_q <= StRefund;
          end else if (select) begin
            // A coin in the same cycle lands before the price check.
            item_out <= item_sel;
            if (coin_ok) credit <= coin_sum[7:0];
            state_q  <= StCheck;
          end else if (coin_ok) begin
            credit <= coin_sum[7:0];
            tcnt_q <= '0;
          end else if (tcnt_q == Tw'(TIMEOUT - 1)) begin
            state_q <= StRefund;
          end else begin
            tcnt_q <= tcnt_q + Tw'(1);
          end
        end
        StCheck: begin
          if (cancel) begin
            state_q <= StRefund;
          end else if (credit >= price) begin
            credit       <= credit - price;
            dispense_req <= 1'b1;
            state_q      <= StDispense;
          end else begin
            insufficient <= 1'b1;
            tcnt_q       <= '0;
            state_q      <= StAccept;
          end
        end
        StDispense: begin
          if (dispense_ack) begin
            dispense_req <= 1'b0;
            state_q      <= (credit != 8'd0) ? StChange : StIdle;
          end
        end
        StChange, StRefund: begin
          if (credit >= Unit) begin
            change_pulse <= 1'b1;
            credit       <= credit - Unit;
            if (credit == Unit) state_q <= StIdle;
          end else begin
            // Residue below one unit (or zero) is dropped without a pulse.
            credit  <= 8'd0;
            state_q <= StIdle;
          end
        end
        default: begin
          credit       <= 8'd0;
          dispense_req <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// Self-checking bench for vend_txn_controller: each scenario schedules stimulus
// rows with their expected output snapshots into a scoreboard queue, then
// replays them and compares the DUT outputs cycle by cycle.
module tb_vend_txn_controller;

  localparam int unsigned TO = 1000;

  logic       clk;
  logic       rst_n;
  logic       coin;
  logic [1:0] coin_val;
  logic       select;
  logic [1:0] item_sel;
  logic       cancel;
  logic       dispense_ack;
  logic [2:0] state;
  logic [7:0] credit;
  logic [1:0] item_out;
  logic       dispense_req;
  logic       change_pulse;
  logic       coin_reject;
  logic       insufficient;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  stim_q[$];
  logic [16:0] exp_q[$];

  vend_txn_controller #(
    .PRICE0     (50),
    .PRICE1     (75),
    .PRICE2     (100),
    .PRICE3     (125),
    .CHANGE_UNIT(5),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin        (coin),
    .coin_val    (coin_val),
    .select      (select),
    .item_sel    (item_sel),
    .cancel      (cancel),
    .dispense_ack(dispense_ack),
    .state       (state),
    .credit      (credit),
    .item_out    (item_out),
    .dispense_req(dispense_req),
    .change_pulse(change_pulse),
    .coin_reject (coin_reject),
    .insufficient(insufficient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input vector: {coin, coin_val, select, item_sel, cancel, ack}
  function automatic logic [7:0] in_v(input logic c, input logic [1:0] cv, input logic s,
                                      input logic [1:0] it, input logic can, input logic ack);
    return {c, cv, s, it, can, ack};
  endfunction

  // Snapshot: {state, credit, item (DISPENSE only), reject, insufficient, req, pulse}
  function automatic logic [16:0] ex(input logic [2:0] st, input logic [7:0] cr,
                                     input logic [1:0] it, input logic rej, input logic ins,
                                     input logic req, input logic p);
    return {st, cr, it, rej, ins, req, p};
  endfunction

  function automatic logic [16:0] obs();
    return {state, credit, (state == 3'd3) ? item_out : 2'd0,
            coin_reject, insufficient, dispense_req, change_pulse};
  endfunction

  task automatic row(input logic [7:0] s, input logic [16:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] v);
    {coin, coin_val, select, item_sel, cancel, dispense_ack} = v;
    @(posedge clk);
    #1;
    {coin, coin_val, select, item_sel, cancel, dispense_ack} = '0;
  endtask

  localparam logic [7:0] Nop = 8'h00;

  task automatic test_reset();
    logic [16:0] want;
    exp_q.push_back(ex(3'd0, 8'd0, 2'd0, 0, 0, 0, 0));
    rst_n = 1'b0;
    coin  = 1'b1;
    coin_val = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    want = exp_q.pop_front();
    n_cmp++;
    if (obs() !== want) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs(), want);
    end
    n_cmp++;
    if (item_out !== 2'd0) begin
      n_err++;
      $display("FAIL reset_item_out: got %0d want 0", item_out);
    end
    coin = 1'b0;
    coin_val = 2'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_exact_pay();
    logic [16:0] got, want;
    int i = 0;
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 25, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 50, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 1, 0, 0, 0), ex(2, 50, 0, 0, 0, 0, 0));
    row(Nop,                    ex(3, 0, 0, 0, 0, 1, 0));
    row(Nop,                    ex(3, 0, 0, 0, 0, 1, 0));
    row(in_v(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0));
    row(Nop,                    ex(0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL exact_pay row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
  endtask

  task automatic test_change();
    logic [16:0] got, want;
    int i = 0;
    row(in_v(1, 3, 0, 0, 0, 0), ex(1, 100, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 1, 1, 0, 0), ex(2, 100, 0, 0, 0, 0, 0));
    row(Nop,                    ex(3, 25, 1, 0, 0, 1, 0));
    row(in_v(0, 0, 0, 0, 0, 1), ex(4, 25, 0, 0, 0, 0, 0));
    for (int k = 1; k < 5; k++) row(Nop, ex(4, 8'(25 - 5 * k), 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL change row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
  endtask

  task automatic test_insufficient();
    logic [16:0] got, want;
    int i = 0;
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 25, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 1, 2, 0, 0), ex(2, 25, 0, 0, 0, 0, 0));
    row(Nop,                    ex(1, 25, 0, 0, 1, 0, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 50, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 75, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 100, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 1, 2, 0, 0), ex(2, 100, 0, 0, 0, 0, 0));
    row(Nop,                    ex(3, 0, 2, 0, 0, 1, 0));
    row(in_v(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL insufficient row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
  endtask

  task automatic test_cancel_coin();
    logic [16:0] got, want;
    int i = 0;
    row(in_v(1, 1, 0, 0, 0, 0), ex(1, 10, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 1, 0), ex(5, 10, 0, 1, 0, 0, 0));
    row(Nop,                    ex(5, 5, 0, 0, 0, 0, 1));
    row(Nop,                    ex(0, 0, 0, 0, 0, 0, 1));
    row(Nop,                    ex(0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL cancel_coin row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
  endtask

  task automatic test_timeout();
    logic [16:0] got, want;
    int i = 0;
    row(in_v(1, 0, 0, 0, 0, 0), ex(1, 5, 0, 0, 0, 0, 0));
    for (int k = 0; k < 600; k++) row(Nop, ex(1, 5, 0, 0, 0, 0, 0));
    // A fresh coin restarts the inactivity window.
    row(in_v(1, 0, 0, 0, 0, 0), ex(1, 10, 0, 0, 0, 0, 0));
    for (int k = 0; k < int'(TO) - 1; k++) row(Nop, ex(1, 10, 0, 0, 0, 0, 0));
    row(Nop, ex(5, 10, 0, 0, 0, 0, 0));
    row(Nop, ex(5, 5, 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL timeout row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
  endtask

  task automatic test_overflow();
    logic [16:0] got, want;
    int i = 0;
    row(in_v(1, 3, 0, 0, 0, 0), ex(1, 100, 0, 0, 0, 0, 0));
    row(in_v(1, 3, 0, 0, 0, 0), ex(1, 200, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 225, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 250, 0, 0, 0, 0, 0));
    row(in_v(1, 1, 0, 0, 0, 0), ex(1, 250, 0, 1, 0, 0, 0));
    row(in_v(1, 0, 0, 0, 0, 0), ex(1, 255, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 0, 0, 1, 0), ex(5, 255, 0, 0, 0, 0, 0));
    for (int k = 1; k < 51; k++) row(Nop, ex(5, 8'(255 - 5 * k), 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL overflow row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
  endtask

  task automatic test_coin_in_dispense();
    logic [16:0] got, want;
    int i = 0;
    row(in_v(1, 3, 0, 0, 0, 0), ex(1, 100, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 1, 0, 0, 0), ex(2, 100, 0, 0, 0, 0, 0));
    row(Nop,                    ex(3, 50, 0, 0, 0, 1, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(3, 50, 0, 1, 0, 1, 0));
    row(in_v(0, 0, 0, 0, 1, 0), ex(3, 50, 0, 0, 0, 1, 0));
    row(in_v(0, 0, 0, 0, 0, 1), ex(4, 50, 0, 0, 0, 0, 0));
    for (int k = 1; k < 10; k++) row(Nop, ex(4, 8'(50 - 5 * k), 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL coin_in_dispense row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] got, want;
    int i = 0;
    // Stray ack/select/cancel in IDLE do nothing; coin+cancel is refused.
    row(in_v(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 1, 3, 0, 0), ex(0, 0, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 0, 0, 1, 0), ex(0, 0, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 1, 0), ex(0, 0, 0, 1, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 25, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 0, 0, 0, 0), ex(1, 50, 0, 0, 0, 0, 0));
    row(in_v(1, 2, 1, 1, 0, 0), ex(2, 75, 0, 0, 0, 0, 0));
    row(Nop,                    ex(3, 0, 1, 0, 0, 1, 0));
    row(in_v(0, 0, 0, 0, 0, 1), ex(0, 0, 0, 0, 0, 0, 0));
    row(in_v(1, 3, 0, 0, 0, 0), ex(1, 100, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 1, 3, 0, 0), ex(2, 100, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 0, 0, 1, 0), ex(5, 100, 0, 0, 0, 0, 0));
    for (int k = 1; k < 20; k++) row(Nop, ex(5, 8'(100 - 5 * k), 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 1));
    row(Nop, ex(0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL back_to_back row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_change();
    logic [16:0] got, want;
    int i = 0;
    row(in_v(1, 3, 0, 0, 0, 0), ex(1, 100, 0, 0, 0, 0, 0));
    row(in_v(0, 0, 1, 0, 0, 0), ex(2, 100, 0, 0, 0, 0, 0));
    row(Nop,                    ex(3, 50, 0, 0, 0, 1, 0));
    row(in_v(0, 0, 0, 0, 0, 1), ex(4, 50, 0, 0, 0, 0, 0));
    row(Nop,                    ex(4, 45, 0, 0, 0, 0, 1));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      got = obs();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL reset_mid row %0d: got st=%0d cr=%0d %h want st=%0d cr=%0d %h",
                 i, got[16:14], got[13:6], got, want[16:14], want[13:6], want);
      end
      i++;
    end
    // Asynchronous: outputs must clear before the next clock edge.
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    got = obs();
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_mid async: got %h want %h", got, want);
    end
    repeat (2) @(posedge clk);
    #1;
    got = obs();
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_mid held: got %h want %h", got, want);
    end
    rst_n = 1'b1;
    drive(Nop);
    got = obs();
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_mid after: got %h want %h", got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {coin, coin_val, select, item_sel, cancel, dispense_ack} = '0;
    test_reset();
    test_exact_pay();
    test_change();
    test_insufficient();
    test_cancel_coin();
    test_timeout();
    test_overflow();
    test_coin_in_dispense();
    test_back_to_back();
    test_reset_mid_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_txn_controller.md
Name: vend_txn_controller

Overview:
- Transaction sequencer for the vending machine datapath.
- Accumulates coin credit, latches an item selection and checks credit against a parameterised price table.
- Drives a dispense handshake to the dispenser mechanism, then pays out change (or a full refund) one unit per cycle.
- Sits above the 5-state IDLE/ACCEPT/CHECK/DISPENSE/CHANGE flow and adds a REFUND path and an inactivity timeout.

Parameters:
- PRICE0, 50, price of item 0 in cents; must be a multiple of CHANGE_UNIT, range 5..255.
- PRICE1, 75, price of item 1 in cents; same rules.
- PRICE2, 100, price of item 2 in cents; same rules.
- PRICE3, 125, price of item 3 in cents; same rules.
- CHANGE_UNIT, 5, cents returned per change_pulse.
- TIMEOUT, 1000, idle cycles in ACCEPT before auto-refund; must be >= 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coin  in  1  one-cycle pulse: a coin is inserted.
- coin_val  in  2  coin value, sampled with coin: 0=5, 1=10, 2=25, 3=100 cents.
- select  in  1  one-cycle pulse: an item is chosen.
- item_sel  in  2  item index, sampled with select.
- cancel  in  1  one-cycle pulse: the customer aborts.
- dispense_ack  in  1  dispenser has completed the vend.
- state  out  3  0=IDLE, 1=ACCEPT, 2=CHECK, 3=DISPENSE, 4=CHANGE, 5=REFUND.
- credit  out  8  current credit in cents.
- item_out  out  2  latched item index; valid while state is DISPENSE.
- dispense_req  out  1  high throughout DISPENSE.
- change_pulse  out  1  one pulse per CHANGE_UNIT paid out.
- coin_reject  out  1  one-cycle pulse: the coin on the previous cycle was refused.
- insufficient  out  1  one-cycle pulse: CHECK failed.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; credit=0; item_out=0; all pulses=0; timeout counter=0.
  - Credit held at reset is discarded and no change is paid.
- All outputs are registered. Pulse outputs are high for exactly one cycle, the cycle after the causing event.
- Coin acceptance, applied when coin=1:
  - Coins are accepted only in IDLE or ACCEPT.
  - Accepted coin: credit <= credit + value.
  - The coin is rejected (coin_reject=1, credit unchanged) in these cases:
    - credit + value > 255 (9-bit compare, no wrap);
    - state is CHECK, DISPENSE, CHANGE or REFUND;
    - cancel is also asserted that cycle.
- IDLE:
  - Accepted coin -> ACCEPT.
  - select or cancel in IDLE is ignored.
- ACCEPT:
  - cancel -> REFUND (cancel has priority over coin and select).
  - Else select -> latch item_sel, go to CHECK. A coin in the same cycle is added first, so CHECK sees the updated credit.
  - Else, when the timeout counter reaches TIMEOUT-1 -> REFUND.
  - Timeout counter: clears on every accepted coin and on entry to ACCEPT; increments on every other ACCEPT cycle.
- CHECK (one cycle):
  - price = PRICE[item] (8-bit).
  - cancel -> REFUND.
  - Else credit >= price -> credit <= credit - price, go to DISPENSE.
  - Else -> insufficient=1, go to ACCEPT with credit unchanged and timeout counter cleared.
- DISPENSE:
  - dispense_req=1 and item_out is held stable.
  - When dispense_ack is sampled high: credit>0 -> CHANGE; credit==0 -> IDLE.
  - dispense_req drops in the same cycle the state leaves DISPENSE.
  - cancel is ignored; there is no timeout.
- CHANGE and REFUND (identical datapath, distinct state codes):
  - While credit >= CHANGE_UNIT: change_pulse=1 and credit <= credit - CHANGE_UNIT, once per cycle.
  - When credit reaches 0 -> IDLE.
  - A residual below CHANGE_UNIT cannot occur with legal parameters. If it does, credit is forced to 0 and the state goes to IDLE.
  - Entry to REFUND with credit 0 (not normally reachable) -> IDLE next cycle with no pulse.
- Undefined state encodings (6, 7) -> IDLE, credit=0.
- dispense_ack outside DISPENSE is ignored.

Test Plan:
- Coins 25, 25 then select item 0 (PRICE0=50) -> CHECK, then DISPENSE with credit=0 and dispense_req=1; after dispense_ack -> IDLE with zero change_pulse cycles.
- Coin 100, select item 1 (75), ack -> CHANGE with credit=25; exactly 5 consecutive change_pulse cycles, then IDLE with credit=0.
- Coin 25, select item 2 (100) -> insufficient pulse and return to ACCEPT with credit=25; then coins 25, 25, 25 and select -> DISPENSE with credit=0.
- Coin 10, then cancel asserted together with a coin 25 -> coin_reject=1, REFUND with credit=10, 2 change_pulse cycles, IDLE.
- Coin 5, then no activity for TIMEOUT cycles -> REFUND, 1 change_pulse, IDLE.
- Credit at 250, then a 10 coin -> coin_reject=1, credit stays 250.
- Coin in DISPENSE -> coin_reject=1.
- rst_n low mid-CHANGE -> state=0 and credit=0 immediately, with no further pulses.
